tb_run_sequencer: RTL and testbench

Test-bench controller that sequences one DUT run. It holds the DUT in reset for a fixed number of cycles, releases it, and counts run cycles. The run ends on done, on fail, or on timeout, and the verdict is latched for the bench to read. It sits between the bench clock generator and the DUT, replacing ad-hoc ready flags in individual benches.

---
 rtl/tb_seq_pkg.sv | 7 +
 rtl/tb_sat_counter.sv | 17 +
 rtl/tb_run_sequencer.sv | 71 +++++++
 tb/tb_tb_run_sequencer.sv | 116 +++++++++++
 4 files changed

// File: rtl/tb_seq_pkg.sv
// tb_seq_pkg: phase encoding and default parameters for the run sequencer.
package tb_seq_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, HOLD_RST = 2'd1, RUN = 2'd2, DONE = 2'd3} tb_seq_phase_t;
  localparam int DEF_RESET_CYCLES = 4;
  localparam int DEF_TIMEOUT_CYCLES = 1024;
  localparam int DEF_CNT_W = 16;
endpackage

// File: rtl/tb_sat_counter.sv
// tb_sat_counter: saturating up-counter with clear, enable and terminal-match flag.
module tb_sat_counter #(
  parameter int W = 16
) (
  input  logic         tb_clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] term,
  output logic [W-1:0] count,
  output logic         hit
);
  always_ff @(posedge tb_clk)
    if (reset || clr) count <= '0;
    else if (en && count != '1) count <= count + W'(1);
  assign hit = count == term;
endmodule

// File: rtl/tb_run_sequencer.sv
// tb_run_sequencer: holds the DUT in reset, runs it, and latches a pass/fail/timeout verdict.
module tb_run_sequencer
  import tb_seq_pkg::*;
#(
  parameter int RESET_CYCLES = DEF_RESET_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             tb_clk,
  input  logic             reset,
  input  logic             start,
  input  logic             dut_done,
  input  logic             dut_fail,
  output logic             dut_reset,
  output logic             dut_run,
  output logic             busy,
  output logic             pass,
  output logic             fail,
  output logic             timeout,
  output logic [CNT_W-1:0] cycle_count,
  output logic [1:0]       phase
);
  if (RESET_CYCLES < 1) begin : g_chk_rst
    $error("RESET_CYCLES must be >= 1");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_chk_to_lo
    $error("TIMEOUT_CYCLES must be >= 1");
  end
  if (longint'(TIMEOUT_CYCLES) >= (longint'(1) << CNT_W)) begin : g_chk_to_hi
    $error("TIMEOUT_CYCLES must be < 2**CNT_W");
  end
  tb_seq_phase_t state, next;
  logic launch, run_clr, hold_hit, run_hit;
  logic [CNT_W-1:0] hold_unused;
  tb_sat_counter #(.W(CNT_W)) u_hold (
    .tb_clk(tb_clk), .reset(reset), .clr(state != HOLD_RST), .en(state == HOLD_RST),
    .term(CNT_W'(RESET_CYCLES - 1)), .count(hold_unused), .hit(hold_hit)
  );
  // Matching TIMEOUT-1 on the current count flags next_count == TIMEOUT_CYCLES.
  tb_sat_counter #(.W(CNT_W)) u_run (
    .tb_clk(tb_clk), .reset(reset), .clr(run_clr), .en(state == RUN),
    .term(CNT_W'(TIMEOUT_CYCLES - 1)), .count(cycle_count), .hit(run_hit)
  );
  always_comb begin
    launch = start && (state == IDLE || state == DONE);
    run_clr = launch || (state == HOLD_RST && hold_hit);
    next = launch ? HOLD_RST :
           (state == HOLD_RST && hold_hit) ? RUN :
           (state == RUN && (dut_fail || dut_done || run_hit)) ? DONE : state;
  end
  always_ff @(posedge tb_clk)
    if (reset) begin
      state <= IDLE;
      dut_reset <= 1'b1;
      dut_run <= 1'b0;
      busy <= 1'b0;
      {pass, fail, timeout} <= '0;
    end else begin
      state <= next;
      dut_reset <= next != RUN;
      dut_run <= next == RUN;
      busy <= next == HOLD_RST || next == RUN;
      if (launch) {pass, fail, timeout} <= '0;
      else if (state == RUN) begin
        fail <= dut_fail;
        pass <= dut_done && !dut_fail;
        timeout <= run_hit && !dut_done && !dut_fail;
      end
    end
  assign phase = state;
endmodule

// File: tb/tb_tb_run_sequencer.sv
// tb_tb_run_sequencer: directed checks of the run sequencer with RESET_CYCLES=4, TIMEOUT_CYCLES=16.
module tb_tb_run_sequencer;
  logic tb_clk = 1'b0, reset = 1'b1, start = 1'b0, dut_done = 1'b0, dut_fail = 1'b0;
  logic dut_reset, dut_run, busy, pass, fail, timeout;
  logic [15:0] cycle_count;
  logic [1:0] phase;
  int total = 0, bad = 0;
  tb_run_sequencer #(.RESET_CYCLES(4), .TIMEOUT_CYCLES(16), .CNT_W(16)) dut (
    .tb_clk(tb_clk), .reset(reset), .start(start), .dut_done(dut_done), .dut_fail(dut_fail),
    .dut_reset(dut_reset), .dut_run(dut_run), .busy(busy), .pass(pass), .fail(fail),
    .timeout(timeout), .cycle_count(cycle_count), .phase(phase)
  );
  always #5 tb_clk = ~tb_clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge tb_clk);
      #1;
    end
  endtask
  // Pulse start and walk through the 4-cycle reset hold into RUN.
  task automatic go_run();
    start = 1'b1;
    step();
    start = 1'b0;
    step(4);
    chk("enter_run", {phase, dut_run, dut_reset}, {2'd2, 1'b1, 1'b0});
  endtask
  initial begin
    step(2);
    reset = 1'b0;
    step();
    chk("rst_phase", phase, 0);
    chk("rst_outs", {dut_reset, dut_run, busy}, 3'b100);
    chk("rst_verdict", {pass, fail, timeout}, 3'b000);
    chk("rst_count", cycle_count, 0);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("hold_enter", {phase, busy, dut_reset, dut_run}, {2'd1, 3'b110});
    dut_done = 1'b1;
    step();
    dut_done = 1'b0;
    chk("hold_ign_done", phase, 1);
    step(2);
    chk("hold_last", {phase, dut_reset}, {2'd1, 1'b1});
    step();
    chk("run_enter", {phase, dut_reset, dut_run, busy}, {2'd2, 3'b011});
    chk("run_cnt0", cycle_count, 0);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("run_ign_start", {phase, cycle_count}, {2'd2, 16'd1});
    step(3);
    dut_done = 1'b1;
    step();
    dut_done = 1'b0;
    chk("pass_state", {phase, dut_reset, dut_run, busy}, {2'd3, 3'b100});
    chk("pass_verdict", {pass, fail, timeout}, 3'b100);
    chk("pass_count", cycle_count, 5);
    dut_fail = 1'b1;
    step(2);
    dut_fail = 1'b0;
    chk("done_hold", {phase, pass, fail, timeout, cycle_count}, {2'd3, 3'b100, 16'd5});
    start = 1'b1;
    step();
    start = 1'b0;
    chk("b2b_clear", {phase, pass, fail, timeout, cycle_count}, {2'd1, 3'b000, 16'd0});
    step(3);
    chk("b2b_hold", {phase, dut_reset}, {2'd1, 1'b1});
    step();
    chk("b2b_run", {phase, cycle_count}, {2'd2, 16'd0});
    step(15);
    chk("to_pre", {phase, cycle_count}, {2'd2, 16'd15});
    step();
    chk("to_verdict", {phase, pass, fail, timeout}, {2'd3, 3'b001});
    chk("to_count", cycle_count, 16);
    step(3);
    chk("to_sat", cycle_count, 16);
    go_run();
    step(2);
    {dut_done, dut_fail} = 2'b11;
    step();
    {dut_done, dut_fail} = 2'b00;
    chk("prio_both", {phase, pass, fail, timeout, cycle_count}, {2'd3, 3'b010, 16'd3});
    go_run();
    dut_fail = 1'b1;
    step();
    dut_fail = 1'b0;
    chk("fail_only", {pass, fail, timeout, cycle_count}, {3'b010, 16'd1});
    go_run();
    step(15);
    dut_done = 1'b1;
    step();
    dut_done = 1'b0;
    chk("last_done", {phase, pass, fail, timeout, cycle_count}, {2'd3, 3'b100, 16'd16});
    go_run();
    step(6);
    chk("abort_pre", cycle_count, 6);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("abort", {phase, pass, fail, timeout, dut_reset, dut_run, busy}, {2'd0, 6'b000100});
    chk("abort_count", cycle_count, 0);
    step();
    chk("abort_idle", phase, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
